// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Optional watchdog enabled with MEM_ARBITER_TIMEOUT_EN.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      GNT_FETCH,
      GNT_DATA
   } arb_grant_t;

   localparam logic [3:0] BE_WORD = 4'hF;

   // In DONE only the requester still waiting keeps the datapath frozen.
   function automatic logic stall_calc(
      input arb_state_t st,
      input arb_grant_t gnt,
      input logic       ireq,
      input logic       dreq
   );
      logic s;
      s = 1'b0;
      unique case (st)
         IDLE:        s = ireq | dreq;
         ISSUE, WAIT: s = 1'b1;
         DONE:        s = (gnt == GNT_DATA) ? ireq : dreq;
         default:     s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Counts busy WAIT cycles and flags expiry at TIMEOUT_CYCLES.
// Instantiated only when MEM_ARBITER_TIMEOUT_EN is defined.
import mem_arbiter_pkg::*;

module mem_arbiter_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  arb_state_t state,
   input  logic       mem_busy,
   output logic       expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == ISSUE) begin
         cnt <= '0;
      end else if (state == WAIT && mem_busy) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (state == WAIT) && mem_busy && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port arbiter: data beats fetch, one bus transaction at a time.
// Define MEM_ARBITER_TIMEOUT_EN to bound WAIT with a watchdog and sticky err.
import mem_arbiter_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   output logic              mem_ren,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_busy,
   output logic              stall,
   output logic              err
);

   arb_state_t        state;
   arb_grant_t        grant;
   logic              is_wr;
   logic              expired;
   logic [DATA_W-1:0] rd_word;

   assign rd_word = expired ? '0 : mem_rdata;
   assign stall   = stall_calc(state, grant, i_req, d_ren | d_wen);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= GNT_FETCH;
         is_wr     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         mem_ren <= 1'b0;
         mem_wen <= 1'b0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (d_ren | d_wen) begin
                  grant     <= GNT_DATA;
                  is_wr     <= d_wen;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
                  mem_ren   <= ~d_wen;
                  mem_wen   <= d_wen;
                  state     <= ISSUE;
               end else if (i_req) begin
                  grant    <= GNT_FETCH;
                  is_wr    <= 1'b0;
                  mem_addr <= i_addr;
                  mem_be   <= BE_WORD;
                  mem_ren  <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (expired || !mem_busy) begin
                  state <= DONE;
                  if (grant == GNT_DATA) begin
                     d_ack <= 1'b1;
                     if (!is_wr) d_rdata <= rd_word;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= rd_word;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   mem_arbiter_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .state    (state),
      .mem_busy (mem_busy),
      .expired  (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else if (expired) err <= 1'b1;
   end
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-table bench for mem_arbiter plus reset and timeout sequences.
// Timeout sequence runs only when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic        stall;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .i_rdata(i_rdata), .i_ack(i_ack),
      .d_ren(d_ren), .d_wen(d_wen),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_rdata(d_rdata),
      .d_ack(d_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ren(mem_ren),
      .mem_wen(mem_wen), .mem_rdata(mem_rdata),
      .mem_busy(mem_busy), .stall(stall),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dbe;
      logic        busy;
      logic [31:0] rdata;
      logic        eren;
      logic        ewen;
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      logic [3:0]  ebe;
      logic        eiack;
      logic        edack;
      logic        estall;
      logic [31:0] eir;
      logic [31:0] edr;
   } vec_t;

   vec_t tbl[$];

   task automatic row(
      input string nm,
      input logic ireq, input logic [31:0] iaddr,
      input logic dren, input logic dwen,
      input logic [31:0] daddr, input logic [31:0] dwdata,
      input logic [3:0] dbe, input logic busy,
      input logic [31:0] rdata,
      input logic eren, input logic ewen,
      input logic [31:0] eaddr, input logic [31:0] ewdata,
      input logic [3:0] ebe,
      input logic eiack, input logic edack, input logic estall,
      input logic [31:0] eir, input logic [31:0] edr
   );
      vec_t v;
      v.nm = nm;
      v.ireq = ireq; v.iaddr = iaddr;
      v.dren = dren; v.dwen = dwen;
      v.daddr = daddr; v.dwdata = dwdata;
      v.dbe = dbe; v.busy = busy; v.rdata = rdata;
      v.eren = eren; v.ewen = ewen;
      v.eaddr = eaddr; v.ewdata = ewdata; v.ebe = ebe;
      v.eiack = eiack; v.edack = edack; v.estall = estall;
      v.eir = eir; v.edr = edr;
      tbl.push_back(v);
   endtask

   task automatic chk(
      input string nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      i_req     = v.ireq;
      i_addr    = v.iaddr;
      d_ren     = v.dren;
      d_wen     = v.dwen;
      d_addr    = v.daddr;
      d_wdata   = v.dwdata;
      d_be      = v.dbe;
      mem_busy  = v.busy;
      mem_rdata = v.rdata;
   endtask

   task automatic quiet();
      i_req = 0; i_addr = 0;
      d_ren = 0; d_wen = 0;
      d_addr = 0; d_wdata = 0; d_be = 0;
      mem_busy = 0; mem_rdata = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".mem_ren"},   32'(mem_ren),   0);
      chk({tag, ".mem_wen"},   32'(mem_wen),   0);
      chk({tag, ".i_ack"},     32'(i_ack),     0);
      chk({tag, ".d_ack"},     32'(d_ack),     0);
      chk({tag, ".err"},       32'(err),       0);
      chk({tag, ".mem_addr"},  mem_addr,       0);
      chk({tag, ".mem_wdata"}, mem_wdata,      0);
      chk({tag, ".mem_be"},    32'(mem_be),    0);
      chk({tag, ".i_rdata"},   i_rdata,        0);
      chk({tag, ".d_rdata"},   d_rdata,        0);
      chk({tag, ".stall"},     32'(stall),     0);
   endtask

   localparam logic [31:0] WA = 32'h3e80_0093;
   localparam logic [31:0] WB = 32'h1111_2222;
   localparam logic [31:0] WC = 32'h00a0_0113;
   localparam logic [31:0] WD = 32'hDEAD_BEEF;
   localparam logic [31:0] WE = 32'hCAFE_F00D;
   localparam logic [31:0] WF = 32'h0000_0077;

   initial begin
      int n;
      rst = 1'b1;
      quiet();

      // inputs | ren wen addr wdata be iack dack stall ir dr
      row("rst_idle", 0,0, 0,0,0,0,0, 0,0,
          0,0,0,0,0, 0,0,0, 0,0);
      row("f_idle", 1,4, 0,0,0,0,0, 0,WA,
          0,0,0,0,0, 0,0,1, 0,0);
      row("f_issue", 1,4, 0,0,0,0,0, 0,WA,
          1,0,4,0,4'hF, 0,0,1, 0,0);
      row("f_wait", 1,4, 0,0,0,0,0, 0,WA,
          0,0,4,0,4'hF, 0,0,1, 0,0);
      row("f_done", 1,4, 0,0,0,0,0, 0,WA,
          0,0,4,0,4'hF, 1,0,0, WA,0);
      row("f_after", 0,0, 0,0,0,0,0, 0,0,
          0,0,4,0,4'hF, 0,0,0, WA,0);
      row("s_idle", 1,8, 1,0,'h100,0,4'hF, 0,WB,
          0,0,4,0,4'hF, 0,0,1, WA,0);
      row("s_d_issue", 1,8, 1,0,'h100,0,4'hF, 0,WB,
          1,0,'h100,0,4'hF, 0,0,1, WA,0);
      row("s_d_wait", 1,8, 1,0,'h100,0,4'hF, 0,WB,
          0,0,'h100,0,4'hF, 0,0,1, WA,0);
      row("s_d_done", 1,8, 1,0,'h100,0,4'hF, 0,WB,
          0,0,'h100,0,4'hF, 0,1,1, WA,WB);
      row("s_f_idle", 1,8, 0,0,0,0,0, 0,WC,
          0,0,'h100,0,4'hF, 0,0,1, WA,WB);
      row("s_f_issue", 1,8, 0,0,0,0,0, 0,WC,
          1,0,8,0,4'hF, 0,0,1, WA,WB);
      row("s_f_wait", 1,8, 0,0,0,0,0, 0,WC,
          0,0,8,0,4'hF, 0,0,1, WA,WB);
      row("s_f_done", 1,8, 0,0,0,0,0, 0,WC,
          0,0,8,0,4'hF, 1,0,0, WC,WB);
      row("st_idle", 0,0, 1,1,'h200,WD,4'h3, 0,'h5555_5555,
          0,0,8,0,4'hF, 0,0,1, WC,WB);
      row("st_issue", 0,0, 1,1,'h200,WD,4'h3, 0,'h5555_5555,
          0,1,'h200,WD,4'h3, 0,0,1, WC,WB);
      row("st_wait", 0,0, 1,1,'h200,WD,4'h3, 0,'h5555_5555,
          0,0,'h200,WD,4'h3, 0,0,1, WC,WB);
      row("st_done", 0,0, 1,1,'h200,WD,4'h3, 0,'h5555_5555,
          0,0,'h200,WD,4'h3, 0,1,0, WC,WB);
      row("st_after", 0,0, 0,0,0,0,0, 0,0,
          0,0,'h200,WD,4'h3, 0,0,0, WC,WB);
      row("ws_idle", 0,0, 1,0,'h300,0,4'hF, 0,0,
          0,0,'h200,WD,4'h3, 0,0,1, WC,WB);
      row("ws_issue", 0,0, 1,0,'h300,0,4'hF, 1,0,
          1,0,'h300,0,4'hF, 0,0,1, WC,WB);
      for (int i = 0; i < 5; i++)
         row("ws_busy", 0,0, 1,0,'h300,0,4'hF, 1,0,
             0,0,'h300,0,4'hF, 0,0,1, WC,WB);
      row("ws_ready", 0,0, 1,0,'h300,0,4'hF, 0,WE,
          0,0,'h300,0,4'hF, 0,0,1, WC,WB);
      row("ws_done", 0,0, 1,0,'h300,0,4'hF, 0,WE,
          0,0,'h300,0,4'hF, 0,1,0, WC,WE);
      row("ws_after", 0,0, 0,0,0,0,0, 0,0,
          0,0,'h300,0,4'hF, 0,0,0, WC,WE);
      row("dr_idle", 1,'hC, 0,0,0,0,0, 0,0,
          0,0,'h300,0,4'hF, 0,0,1, WC,WE);
      row("dr_issue", 0,0, 0,0,0,0,0, 0,0,
          1,0,'hC,0,4'hF, 0,0,1, WC,WE);
      row("dr_wait", 0,0, 0,0,0,0,0, 0,WF,
          0,0,'hC,0,4'hF, 0,0,1, WC,WE);
      row("dr_done", 0,0, 0,0,0,0,0, 0,WF,
          0,0,'hC,0,4'hF, 1,0,0, WF,WE);
      row("dr_after", 0,0, 0,0,0,0,0, 0,0,
          0,0,'hC,0,4'hF, 0,0,0, WF,WE);

      repeat (2) @(negedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         vec_t v;
         v = tbl[i];
         drive(v);
         #1;
         chk({v.nm, ".mem_ren"},   32'(mem_ren), 32'(v.eren));
         chk({v.nm, ".mem_wen"},   32'(mem_wen), 32'(v.ewen));
         chk({v.nm, ".mem_addr"},  mem_addr,     v.eaddr);
         chk({v.nm, ".mem_wdata"}, mem_wdata,    v.ewdata);
         chk({v.nm, ".mem_be"},    32'(mem_be),  32'(v.ebe));
         chk({v.nm, ".i_ack"},     32'(i_ack),   32'(v.eiack));
         chk({v.nm, ".d_ack"},     32'(d_ack),   32'(v.edack));
         chk({v.nm, ".stall"},     32'(stall),   32'(v.estall));
         chk({v.nm, ".i_rdata"},   i_rdata,      v.eir);
         chk({v.nm, ".d_rdata"},   d_rdata,      v.edr);
         chk({v.nm, ".err"},       32'(err),     0);
         @(negedge clk);
      end

      // Reset while a load sits in WAIT with the memory busy.
      d_ren = 1; d_addr = 32'h400; d_be = 4'hF;
      @(negedge clk);
      #1;
      chk("rw_issue.mem_ren", 32'(mem_ren), 1);
      mem_busy = 1;
      @(negedge clk);
      #1;
      chk("rw_wait.stall", 32'(stall), 1);
      chk("rw_wait.mem_addr", mem_addr, 32'h400);
      #1;
      rst = 1'b1;
      quiet();
      #1;
      chk_reset_vals("rw_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rw_after.d_ack", 32'(d_ack), 0);
         chk("rw_after.mem_ren", 32'(mem_ren), 0);
         @(negedge clk);
      end

`ifdef MEM_ARBITER_TIMEOUT_EN
      // Fetch against a memory that never drops busy.
      i_req = 1; i_addr = 32'h10; mem_busy = 1;
      mem_rdata = 32'hFFFF_FFFF;
      n = 0;
      #1;
      while (!i_ack && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("to.latency", 32'(n), 10);
      chk("to.i_ack", 32'(i_ack), 1);
      chk("to.i_rdata", i_rdata, 0);
      chk("to.err", 32'(err), 1);
      i_req = 0; mem_busy = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("to.err_sticky", 32'(err), 1);
      rst = 1'b1;
      #1;
      chk("to.err_reset", 32'(err), 0);
      @(negedge clk);
      rst = 1'b0;
`else
      n = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
